// File: rtl/tmds_pkg.sv
// tmds_pkg: shared constants, stage-1 bundle and helpers for the TMDS encoder.
// TMDS_ENC_OUT_REG_EN selects the extra output register and therefore the latency.
package tmds_pkg;
  localparam int CNT_W = 5;
  localparam logic [9:0] CTRL_00 = 10'h354;
  localparam logic [9:0] CTRL_01 = 10'h0AB;
  localparam logic [9:0] CTRL_10 = 10'h154;
  localparam logic [9:0] CTRL_11 = 10'h2AB;
`ifdef TMDS_ENC_OUT_REG_EN
  localparam int LATENCY = 3;
`else
  localparam int LATENCY = 2;
`endif
  typedef struct packed {
    logic       de;
    logic [1:0] c;
    logic [8:0] q_m;
  } stage1_t;
  function automatic logic [3:0] ones8(input logic [7:0] v);
    logic [3:0] n;
    n = '0;
    for (int i = 0; i < 8; i++) n += {3'b000, v[i]};
    return n;
  endfunction
  // XNOR chain is the XOR chain with every stage inverted
  function automatic logic [8:0] tm_encode(input logic [7:0] d);
    logic [3:0] n1;
    logic       xn;
    logic [8:0] q;
    n1 = ones8(d);
    xn = (n1 > 4'd4) || (n1 == 4'd4 && !d[0]);
    q[0] = d[0];
    for (int i = 1; i < 8; i++) q[i] = q[i-1] ^ d[i] ^ xn;
    q[8] = ~xn;
    return q;
  endfunction
  function automatic logic [9:0] ctrl_sym(input logic [1:0] c);
    return c == 2'b00 ? CTRL_00 : c == 2'b01 ? CTRL_01 : c == 2'b10 ? CTRL_10 : CTRL_11;
  endfunction
endpackage

// File: rtl/tmds_encoder_if.sv
// tmds_encoder_if: pixel-side video bus and the three TMDS symbol outputs.
interface tmds_encoder_if;
  logic       I_de;
  logic       I_hs;
  logic       I_vs;
  logic [7:0] I_data_r;
  logic [7:0] I_data_g;
  logic [7:0] I_data_b;
  logic [9:0] O_tmds_r;
  logic [9:0] O_tmds_g;
  logic [9:0] O_tmds_b;
  modport master(output I_de, I_hs, I_vs, I_data_r, I_data_g, I_data_b,
                 input O_tmds_r, O_tmds_g, O_tmds_b);
  modport slave(input I_de, I_hs, I_vs, I_data_r, I_data_g, I_data_b,
                output O_tmds_r, O_tmds_g, O_tmds_b);
endinterface

// File: rtl/tmds_chan_enc.sv
// tmds_chan_enc: one TMDS channel, transition minimisation then DC balance.
// TMDS_ENC_OUT_REG_EN adds one more register on the symbol output.
module tmds_chan_enc
  import tmds_pkg::*;
(
  input  logic       I_pxl_clk,
  input  logic       I_rst,
  input  logic       I_de,
  input  logic [1:0] I_ctrl,
  input  logic [7:0] I_data,
  output logic [9:0] O_tmds
);
  stage1_t                  s1;
  logic signed [CNT_W-1:0]  cnt, cnt_d, diff;
  logic [3:0]               n1q;
  logic [7:0]               qm;
  logic                     qm8;
  logic [9:0]               q, q_d;
  always_comb begin
    qm   = s1.q_m[7:0];
    qm8  = s1.q_m[8];
    n1q  = ones8(qm);
    diff = $signed({1'b0, n1q}) - $signed({1'b0, 4'd8 - n1q});
    q_d   = ctrl_sym(s1.c);
    cnt_d = '0;
    if (s1.de) begin
      if (cnt == '0 || diff == '0) begin
        q_d   = {~qm8, qm8, qm8 ? qm : ~qm};
        cnt_d = qm8 ? cnt + diff : cnt - diff;
      end else if ((cnt > 5'sd0 && diff > 5'sd0) || (cnt < 5'sd0 && diff < 5'sd0)) begin
        q_d   = {1'b1, qm8, ~qm};
        cnt_d = cnt + (qm8 ? 5'sd2 : 5'sd0) - diff;
      end else begin
        q_d   = {1'b0, qm8, qm};
        cnt_d = cnt - (qm8 ? 5'sd0 : 5'sd2) + diff;
      end
    end
  end
  always_ff @(posedge I_pxl_clk or posedge I_rst) begin
    if (I_rst) begin
      s1  <= '0;
      cnt <= '0;
      q   <= CTRL_00;
    end else begin
      s1  <= '{de: I_de, c: I_ctrl, q_m: tm_encode(I_data)};
      cnt <= cnt_d;
      q   <= q_d;
    end
  end
`ifdef TMDS_ENC_OUT_REG_EN
  logic [9:0] q_out;
  always_ff @(posedge I_pxl_clk or posedge I_rst) begin
    if (I_rst) q_out <= CTRL_00;
    else q_out <= q;
  end
  assign O_tmds = q_out;
`else
  assign O_tmds = q;
`endif
endmodule

// File: rtl/tmds_encoder.sv
// tmds_encoder: three lockstep TMDS channels; HS/VS ride on blue during blanking.
// Latency 2, or 3 with TMDS_ENC_OUT_REG_EN defined.
module tmds_encoder (
  input logic           I_pxl_clk,
  input logic           I_rst,
  tmds_encoder_if.slave bus
);
  tmds_chan_enc u_r (
    .I_pxl_clk (I_pxl_clk),
    .I_rst     (I_rst),
    .I_de      (bus.I_de),
    .I_ctrl    (2'b00),
    .I_data    (bus.I_data_r),
    .O_tmds    (bus.O_tmds_r)
  );
  tmds_chan_enc u_g (
    .I_pxl_clk (I_pxl_clk),
    .I_rst     (I_rst),
    .I_de      (bus.I_de),
    .I_ctrl    (2'b00),
    .I_data    (bus.I_data_g),
    .O_tmds    (bus.O_tmds_g)
  );
  tmds_chan_enc u_b (
    .I_pxl_clk (I_pxl_clk),
    .I_rst     (I_rst),
    .I_de      (bus.I_de),
    .I_ctrl    ({bus.I_vs, bus.I_hs}),
    .I_data    (bus.I_data_b),
    .O_tmds    (bus.O_tmds_b)
  );
endmodule

// File: tb/tb_tmds_encoder.sv
// tb_tmds_encoder: scoreboard bench for tmds_encoder against a reference TMDS model.
// Honours TMDS_ENC_OUT_REG_EN for the expected latency.
module tb_tmds_encoder;
`ifdef TMDS_ENC_OUT_REG_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 2;
`endif
  typedef struct {
    logic [9:0] r;
    logic [9:0] g;
    logic [9:0] b;
  } exp_t;
  logic  clk = 1'b0;
  logic  rst = 1'b1;
  exp_t  sb[$];
  string tags[$];
  string cur = "init";
  int    n_vec = 0;
  int    n_err = 0;
  int    cnt_r = 0, cnt_g = 0, cnt_b = 0;
  tmds_encoder_if bus();
  tmds_encoder dut (
    .I_pxl_clk (clk),
    .I_rst     (rst),
    .bus       (bus)
  );
  always #5 clk = ~clk;
  function automatic logic [9:0] ref_enc(input logic [7:0] d, input logic de, input logic [1:0] c, inout int cnt);
    int         n1, o, z, dis;
    bit         xn;
    logic [8:0] qm;
    if (!de) begin
      cnt = 0;
      case (c)
        2'b00:   return 10'b1101010100;
        2'b01:   return 10'b0010101011;
        2'b10:   return 10'b0101010100;
        default: return 10'b1010101011;
      endcase
    end
    n1 = $countones(d);
    xn = (n1 > 4) || (n1 == 4 && d[0] == 1'b0);
    qm[0] = d[0];
    for (int i = 1; i < 8; i++) qm[i] = xn ? ~(qm[i-1] ^ d[i]) : (qm[i-1] ^ d[i]);
    qm[8] = !xn;
    o = $countones(qm[7:0]);
    z = 8 - o;
    dis = o - z;
    if (cnt == 0 || o == z) begin
      cnt = cnt + (qm[8] ? dis : -dis);
      return {~qm[8], qm[8], qm[8] ? qm[7:0] : ~qm[7:0]};
    end
    if ((cnt > 0 && o > z) || (cnt < 0 && z > o)) begin
      cnt = cnt + 2 * int'(qm[8]) - dis;
      return {1'b1, qm[8], ~qm[7:0]};
    end
    cnt = cnt - 2 * int'(!qm[8]) + dis;
    return {1'b0, qm[8], qm[7:0]};
  endfunction
  task automatic set_idle();
    bus.I_de = 1'b0;
    bus.I_hs = 1'b0;
    bus.I_vs = 1'b0;
    bus.I_data_r = 8'h00;
    bus.I_data_g = 8'h00;
    bus.I_data_b = 8'h00;
  endtask
  task automatic prefill();
    exp_t e;
    e = '{10'h354, 10'h354, 10'h354};
    sb.delete();
    tags.delete();
    for (int i = 0; i < LAT; i++) begin
      sb.push_back(e);
      tags.push_back({cur, "_release"});
    end
    cnt_r = 0;
    cnt_g = 0;
    cnt_b = 0;
  endtask
  task automatic cycle(input logic de, input logic hs, input logic vs,
                       input logic [7:0] r, input logic [7:0] g, input logic [7:0] b,
                       input bit lit = 1'b0, input logic [9:0] er = '0,
                       input logic [9:0] eg = '0, input logic [9:0] eb = '0);
    exp_t  e, m;
    string t;
    @(negedge clk);
    e = sb.pop_front();
    t = tags.pop_front();
    n_vec++;
    if (bus.O_tmds_r !== e.r) begin
      n_err++;
      $display("FAIL %s red: got %h expected %h", t, bus.O_tmds_r, e.r);
    end
    n_vec++;
    if (bus.O_tmds_g !== e.g) begin
      n_err++;
      $display("FAIL %s green: got %h expected %h", t, bus.O_tmds_g, e.g);
    end
    n_vec++;
    if (bus.O_tmds_b !== e.b) begin
      n_err++;
      $display("FAIL %s blue: got %h expected %h", t, bus.O_tmds_b, e.b);
    end
    bus.I_de = de;
    bus.I_hs = hs;
    bus.I_vs = vs;
    bus.I_data_r = r;
    bus.I_data_g = g;
    bus.I_data_b = b;
    m.r = ref_enc(r, de, 2'b00, cnt_r);
    m.g = ref_enc(g, de, 2'b00, cnt_g);
    m.b = ref_enc(b, de, {vs, hs}, cnt_b);
    if (lit) m = '{er, eg, eb};
    sb.push_back(m);
    tags.push_back(cur);
  endtask
  task automatic test_reset();
    cur = "reset";
    set_idle();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    n_vec++;
    if (bus.O_tmds_r !== 10'h354) begin n_err++; $display("FAIL reset red: got %h expected 354", bus.O_tmds_r); end
    n_vec++;
    if (bus.O_tmds_g !== 10'h354) begin n_err++; $display("FAIL reset green: got %h expected 354", bus.O_tmds_g); end
    n_vec++;
    if (bus.O_tmds_b !== 10'h354) begin n_err++; $display("FAIL reset blue: got %h expected 354", bus.O_tmds_b); end
    rst = 1'b0;
    prefill();
    repeat (3) cycle(0, 0, 0, 8'h00, 8'h00, 8'h00, 1, 10'h354, 10'h354, 10'h354);
  endtask
  task automatic test_ctrl();
    cur = "ctrl_hs";
    cycle(0, 1, 0, 8'h12, 8'h34, 8'h56, 1, 10'h354, 10'h354, 10'h0AB);
    cur = "ctrl_vs";
    cycle(0, 0, 1, 8'h78, 8'h9A, 8'hBC, 1, 10'h354, 10'h354, 10'h154);
    cur = "ctrl_both";
    cycle(0, 1, 1, 8'hDE, 8'hF0, 8'h0F, 1, 10'h354, 10'h354, 10'h2AB);
    cur = "ctrl_idle";
    cycle(0, 0, 0, 8'h00, 8'h00, 8'h00, 1, 10'h354, 10'h354, 10'h354);
  endtask
  task automatic test_zeros_and_line();
    cur = "zeros0";
    cycle(1, 0, 0, 8'h00, 8'h00, 8'h00, 1, 10'h100, 10'h100, 10'h100);
    cur = "zeros1";
    cycle(1, 0, 0, 8'h00, 8'h00, 8'h00, 1, 10'h3FF, 10'h3FF, 10'h3FF);
    cur = "zeros2";
    cycle(1, 0, 0, 8'h00, 8'h00, 8'h00, 1, 10'h100, 10'h100, 10'h100);
    cur = "line_blank";
    cycle(0, 0, 0, 8'h00, 8'h00, 8'h00, 1, 10'h354, 10'h354, 10'h354);
    cur = "line_restart";
    cycle(1, 0, 0, 8'h00, 8'h00, 8'h00, 1, 10'h100, 10'h100, 10'h100);
    cur = "line_end";
    cycle(0, 0, 0, 8'h00, 8'h00, 8'h00, 1, 10'h354, 10'h354, 10'h354);
  endtask
  task automatic test_xnor();
    cur = "xnor_ff";
    cycle(1, 0, 0, 8'h00, 8'hFF, 8'h00, 1, 10'h100, 10'h200, 10'h100);
    cur = "xnor_follow";
    cycle(1, 0, 0, 8'hA5, 8'h3C, 8'h0F);
    cycle(1, 0, 0, 8'h10, 8'hE7, 8'h81);
    cycle(0, 0, 0, 8'h00, 8'h00, 8'h00);
  endtask
  task automatic test_random();
    cur = "random";
    for (int i = 0; i < 60; i++)
      cycle($urandom_range(0, 3) != 0, 1'($urandom), 1'($urandom),
            8'($urandom), 8'($urandom), 8'($urandom));
  endtask
  task automatic test_midline_reset();
    cur = "midline_pre";
    for (int i = 0; i < 4; i++) cycle(1, 0, 0, 8'h00, 8'h00, 8'h00);
    @(posedge clk);
    #2;
    rst = 1'b1;
    set_idle();
    #1;
    n_vec++;
    if (bus.O_tmds_r !== 10'h354) begin n_err++; $display("FAIL midline_reset red: got %h expected 354", bus.O_tmds_r); end
    n_vec++;
    if (bus.O_tmds_g !== 10'h354) begin n_err++; $display("FAIL midline_reset green: got %h expected 354", bus.O_tmds_g); end
    n_vec++;
    if (bus.O_tmds_b !== 10'h354) begin n_err++; $display("FAIL midline_reset blue: got %h expected 354", bus.O_tmds_b); end
    repeat (2) @(negedge clk);
    cur = "midline_release";
    rst = 1'b0;
    prefill();
    cycle(1, 0, 0, 8'h00, 8'h00, 8'h00, 1, 10'h100, 10'h100, 10'h100);
    cycle(1, 0, 0, 8'h00, 8'h00, 8'h00, 1, 10'h3FF, 10'h3FF, 10'h3FF);
  endtask
  initial begin
    set_idle();
    test_reset();
    test_ctrl();
    test_zeros_and_line();
    test_xnor();
    test_random();
    test_midline_reset();
    cur = "flush";
    repeat (LAT + 1) cycle(0, 0, 0, 8'h00, 8'h00, 8'h00);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
